// File: rtl/cpu2wishbone_master_bridge.sv
// Wishbone classic-cycle master for the CPU pipeline.
// Turns one RAM-style CPU request into a single Wishbone transaction.
// The pipeline is held with a stall request until the slave acks, a flush kills
// the transaction, or the timeout counter aborts it.
module cpu2wishbone_master_bridge #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int SEL_WIDTH     = 4,
    parameter int TIMEOUT_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_ce_i,
    input  logic                  cpu_we_i,
    input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
    input  logic [DATA_WIDTH-1:0] cpu_data_i,
    input  logic [SEL_WIDTH-1:0]  cpu_sel_i,
    output logic [DATA_WIDTH-1:0] cpu_data_o,
    output logic                  cpu_err_o,
    input  logic                  stall_i,
    input  logic                  flush_i,
    output logic                  stallreq_o,
    output logic                  wishbone_cyc_o,
    output logic                  wishbone_stb_o,
    output logic                  wishbone_we_o,
    output logic [ADDR_WIDTH-1:0] wishbone_addr_o,
    output logic [DATA_WIDTH-1:0] wishbone_data_o,
    output logic [SEL_WIDTH-1:0]  wishbone_sel_o,
    input  logic [DATA_WIDTH-1:0] wishbone_data_i,
    input  logic                  wishbone_ack_i
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    localparam logic [TIMEOUT_WIDTH-1:0] CNT_MAX = '1;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic                     r_cyc;
    logic                     r_stb;
    logic                     r_we;
    logic [ADDR_WIDTH-1:0]    r_addr;
    logic [DATA_WIDTH-1:0]    r_data;
    logic [SEL_WIDTH-1:0]     r_sel;
    logic [DATA_WIDTH-1:0]    r_rd_buf;
    logic [TIMEOUT_WIDTH-1:0] r_cnt;

    logic                     w_cyc;
    logic                     w_stb;
    logic                     w_we;
    logic [ADDR_WIDTH-1:0]    w_addr;
    logic [DATA_WIDTH-1:0]    w_data;
    logic [SEL_WIDTH-1:0]     w_sel;
    logic [DATA_WIDTH-1:0]    w_rd_buf;
    logic [TIMEOUT_WIDTH-1:0] w_cnt;
    logic                     w_stallreq;
    logic                     w_err;
    logic [DATA_WIDTH-1:0]    w_cpu_data;

    // State, bus outputs, read buffer and timeout counter; everything clears on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cyc    <= 1'b0;
            r_stb    <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_data   <= '0;
            r_sel    <= '0;
            r_rd_buf <= '0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cyc    <= w_cyc;
            r_stb    <= w_stb;
            r_we     <= w_we;
            r_addr   <= w_addr;
            r_data   <= w_data;
            r_sel    <= w_sel;
            r_rd_buf <= w_rd_buf;
            r_cnt    <= w_cnt;
        end
    end

    // Next-state and combinational outputs; in BUSY, flush beats ack beats timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_cyc       = r_cyc;
        w_stb       = r_stb;
        w_we        = r_we;
        w_addr      = r_addr;
        w_data      = r_data;
        w_sel       = r_sel;
        w_rd_buf    = r_rd_buf;
        w_cnt       = r_cnt;
        w_stallreq  = 1'b0;
        w_err       = 1'b0;
        w_cpu_data  = r_rd_buf;

        case (r_state)
            S_IDLE: begin
                if (cpu_ce_i && !flush_i) begin
                    w_cyc       = 1'b1;
                    w_stb       = 1'b1;
                    w_we        = cpu_we_i;
                    w_addr      = cpu_addr_i;
                    w_data      = cpu_data_i;
                    w_sel       = cpu_sel_i;
                    w_cnt       = '0;
                    w_stallreq  = 1'b1;
                    w_state_nxt = S_BUSY;
                end
            end

            S_BUSY: begin
                // Read data is forwarded in the ack cycle so the CPU sees it without
                // waiting for the buffer to update.
                if (wishbone_ack_i && !r_we) begin
                    w_cpu_data = wishbone_data_i;
                end
                if (flush_i || wishbone_ack_i || (r_cnt == CNT_MAX)) begin
                    w_cyc  = 1'b0;
                    w_stb  = 1'b0;
                    w_we   = 1'b0;
                    w_addr = '0;
                    w_data = '0;
                    w_sel  = '0;
                end
                if (flush_i) begin
                    w_state_nxt = S_IDLE;
                end else if (wishbone_ack_i) begin
                    if (!r_we) begin
                        w_rd_buf = wishbone_data_i;
                    end
                    w_state_nxt = stall_i ? S_WAIT : S_IDLE;
                end else if (r_cnt == CNT_MAX) begin
                    w_err       = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt      = r_cnt + 1'b1;
                    w_stallreq = 1'b1;
                end
            end

            S_WAIT: begin
                // A request still held by the frozen pipeline must not be reissued.
                if (!stall_i || flush_i) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign wishbone_cyc_o  = r_cyc;
    assign wishbone_stb_o  = r_stb;
    assign wishbone_we_o   = r_we;
    assign wishbone_addr_o = r_addr;
    assign wishbone_data_o = r_data;
    assign wishbone_sel_o  = r_sel;
    assign stallreq_o      = w_stallreq;
    assign cpu_err_o       = w_err;
    assign cpu_data_o      = w_cpu_data;

endmodule

// File: doc/cpu2wishbone_master_bridge.md
Name: cpu2wishbone_master_bridge

Overview:
Wishbone classic-cycle master that turns the CPU pipeline's RAM-style request (ce/we/addr/data/sel) into single Wishbone transactions. It holds the pipeline with a stall request until the slave acks, then returns read data. It handles pipeline flush and pipeline stall, and aborts hung transactions with a timeout. It sits between the OpenMIPS core's instruction or data port and the Wishbone interconnect, facing bus slaves such as the RAM bridge.

Parameters:
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width
SEL_WIDTH, 4, byte-select width
TIMEOUT_WIDTH, 8, timeout counter width; abort after 2^TIMEOUT_WIDTH-1 BUSY cycles without ack

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  reset, asynchronous, active-high
cpu_ce_i  in  1  CPU request valid
cpu_we_i  in  1  1 = write, 0 = read
cpu_addr_i  in  ADDR_WIDTH  request address
cpu_data_i  in  DATA_WIDTH  write data
cpu_sel_i  in  SEL_WIDTH  byte enables
cpu_data_o  out  DATA_WIDTH  read data to CPU
cpu_err_o  out  1  one-cycle pulse on timeout abort
stall_i  in  1  pipeline stalled by another source
flush_i  in  1  pipeline flush
stallreq_o  out  1  stall request to pipeline control
wishbone_cyc_o  out  1  bus cycle
wishbone_stb_o  out  1  strobe
wishbone_we_o  out  1  write enable
wishbone_addr_o  out  ADDR_WIDTH  address
wishbone_data_o  out  DATA_WIDTH  write data
wishbone_sel_o  out  SEL_WIDTH  byte selects
wishbone_data_i  in  DATA_WIDTH  read data from slave
wishbone_ack_i  in  1  slave acknowledge

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; all wishbone_*_o = 0.
  - rd_buf = 0, so cpu_data_o = 0.
  - timeout counter = 0; cpu_err_o = 0.
- All wishbone_*_o are registered. stallreq_o and cpu_data_o are combinational from state and inputs.
- States:
  - IDLE: if cpu_ce_i & !flush_i:
    - Register cyc=stb=1, we/addr/data/sel from the cpu_* inputs.
    - Clear the counter; go to BUSY.
    - stallreq_o = 1 this cycle.
    - Otherwise stallreq_o = 0 and the wishbone outputs stay 0.
  - BUSY: priority is flush > ack > timeout.
    - flush_i: clear cyc/stb/we/addr/data/sel; go to IDLE. Data is discarded, even if ack_i is also high, and cpu_err_o stays 0. stallreq_o = 0.
    - ack_i: clear the wishbone outputs. If !we, rd_buf <= wishbone_data_i. stallreq_o = 0. Go to WAIT_STALL if stall_i, else IDLE.
    - Counter = 2^TIMEOUT_WIDTH-1 and no ack: clear the wishbone outputs; cpu_err_o = 1 for this cycle; stallreq_o = 0; go to IDLE.
    - Otherwise: counter++, stallreq_o = 1, and the wishbone outputs are held stable.
  - WAIT_STALL (pipeline frozen after completion):
    - stallreq_o = 0; cpu_data_o = rd_buf.
    - Go to IDLE when !stall_i or flush_i.
    - The cpu_* request is ignored here, so a held request is not reissued.
- cpu_data_o = wishbone_data_i when (BUSY & ack_i & !we_o); otherwise rd_buf. Writes never update rd_buf.
- wishbone_ack_i is ignored outside BUSY.
- Latency:
  - Request seen in cycle N; cyc/stb high from N+1.
  - With ack in N+1, stallreq_o is high only in cycle N and read data is valid in N+1.
  - Back-to-back requests have at least one cycle with cyc=0 between them.
- Addr, data, sel and we never change while cyc=1.
- Counter saturates logic-wise at abort; it is never wrapped.

Test Plan:
- Single read: ce=1, we=0, addr=0x100, sel=0xF. Slave acks 2 cycles after stb with data 0xDEADBEEF. Required:
  - stallreq_o=1 for 3 cycles.
  - cpu_data_o=0xDEADBEEF in the ack cycle.
  - rd_buf=0xDEADBEEF afterwards; cyc=0 the next cycle.
- Single write: addr=0x204, data=0x12345678, sel=0x3, ack in the first stb cycle. Required:
  - wishbone we=1, sel=0x3, data=0x12345678.
  - stallreq_o high 1 cycle.
  - rd_buf unchanged.
- Flush mid-transaction: flush_i in the 2nd BUSY cycle, with ack_i asserted in the same cycle. Required:
  - cyc=0 the next cycle; state IDLE; rd_buf unchanged; cpu_err_o=0.
- Pipeline stall after a read: stall_i=1 for 3 cycles after ack (data 0xA5A5A5A5), with ce held. Required:
  - cpu_data_o holds 0xA5A5A5A5 and no new cyc during the stall.
  - A new transaction starts the cycle after stall_i falls.
- Timeout: TIMEOUT_WIDTH=4, slave never acks. Required:
  - Abort after 15 BUSY cycles; cpu_err_o pulses 1 cycle; stallreq_o=0; cyc=0.
  - A late ack is ignored.
- Reset mid-transaction: assert rst while cyc=1. Required:
  - All outputs 0 immediately (asynchronous), state IDLE; normal operation after release.
